net_settle_sequencer: RTL

Clocked scheduler for the switch-level NMOS net datapath built from the transistor, pullup and pad models. It holds the registered net-state vector and latches pad inputs on request. It iterates the combinational transistor network one relaxation step per clock until all nets are stable for a programmable number of steps, then reports completion. Sits between the emulated CPU phase-clock generator and the extracted netlist, and flags non-converging (oscillating) networks.

---
 rtl/net_settle_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/net_settle_sequencer.sv
// ============================================================================
// Module  : net_settle_sequencer
// Brief   : Clocked relaxation scheduler for a switch-level NMOS net array.
//           It iterates the net network until the nets settle, and flags
//           networks that oscillate.
//           Optional macro SETTLE_TRACE_EN adds two trace outputs:
//           o_max_iter_seen and o_chg_mask.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module net_settle_sequencer #(
    parameter int W             = 4,
    parameter int NETS          = 64,
    parameter int NPADS         = 8,
    parameter int MAX_ITER      = 255,
    parameter int STABLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [NPADS-1:0]    i_pad_in,
    output logic [NPADS-1:0]    o_pad_hold,
    input  logic [NETS*W-1:0]   i_nets_next,
    output logic [NETS*W-1:0]   o_nets_q,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_osc_err,
    output logic [7:0]          o_iter_cnt
`ifdef SETTLE_TRACE_EN
    ,
    output logic [7:0]          o_max_iter_seen,
    output logic [NETS-1:0]     o_chg_mask
`endif
);

    localparam logic [3:0] c_STABLE = 4'(STABLE_CYCLES);
    localparam logic [7:0] c_MAX    = 8'(MAX_ITER);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    logic [NPADS-1:0]    r_pad_hold;
    logic [NETS*W-1:0]   r_nets_q;
    logic                r_busy;
    logic                r_done;
    logic                r_osc_err;
    logic [7:0]          r_iter;
    logic [3:0]          r_stable;

    logic                w_same;
    logic [3:0]          w_stable_nxt;
    logic [7:0]          w_iter_nxt;

    always_comb begin
        w_same       = (i_nets_next == r_nets_q);
        w_stable_nxt = w_same ? (r_stable + 4'd1) : 4'd0;
        w_iter_nxt   = (r_iter == 8'hFF) ? r_iter : (r_iter + 8'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pad_hold <= '0;
            r_nets_q   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_osc_err  <= 1'b0;
            r_iter     <= 8'd0;
            r_stable   <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new start directly, with no IDLE gap
                    if (i_start) begin
                        r_pad_hold <= i_pad_in;
                        r_iter     <= 8'd0;
                        r_stable   <= 4'd0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SETTLE;
                    end else begin
                        r_state    <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    r_nets_q <= i_nets_next;
                    r_iter   <= w_iter_nxt;
                    r_stable <= w_stable_nxt;
                    // Settling takes priority over the iteration limit on the same step
                    if (w_stable_nxt == c_STABLE) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_iter_nxt >= c_MAX) begin
                        r_busy    <= 1'b0;
                        r_osc_err <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_pad_hold = r_pad_hold;
    assign o_nets_q   = r_nets_q;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_osc_err  = r_osc_err;
    assign o_iter_cnt = r_iter;

`ifdef SETTLE_TRACE_EN
    logic [NETS-1:0] w_chg;
    logic [NETS-1:0] r_chg_mask;
    logic [7:0]      r_max_iter;

    for (genvar gi = 0; gi < NETS; gi++) begin : g_chg
        assign w_chg[gi] = (i_nets_next[gi*W +: W] != r_nets_q[gi*W +: W]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chg_mask <= '0;
            r_max_iter <= 8'd0;
        end else begin
            if (r_state == S_SETTLE) begin
                r_chg_mask <= r_chg_mask | w_chg;
            end else if (i_start) begin
                r_chg_mask <= '0;
            end
            if (r_state == S_DONE && r_iter > r_max_iter) begin
                r_max_iter <= r_iter;
            end
        end
    end

    assign o_chg_mask      = r_chg_mask;
    assign o_max_iter_seen = r_max_iter;
`endif

endmodule

`default_nettype wire
